// File: rtl/unpacker_pkg.sv
// Shared types and constants for the unpacker front end: beat geometry,
// arbiter state encoding and a valid-byte-count range check.
package unpacker_pkg;

  localparam int DATA_W  = 1280;
  localparam int VBC_W   = 8;
  localparam int MAX_VBC = 160;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    GRANT = 2'd1,
    LOCK  = 2'd2
  } arb_state_t;

  // A beat may carry at most MAX_VBC valid bytes; anything larger is malformed.
  function automatic logic vbc_over(input logic [VBC_W-1:0] vbc);
    return (vbc > VBC_W'(MAX_VBC));
  endfunction

endpackage

// File: rtl/unpacker_arb_if.sv
// Bundle of the per-requester beat lanes and the single unpacker-facing lane.
// The master side (requesters + unpacker model) drives beats and u_ready;
// the slave side (the arbiter) drives req_ready and the u_* beat.
interface unpacker_arb_if #(
  parameter int N_REQ = 4
) ();
  import unpacker_pkg::*;

  logic [N_REQ-1:0]        req_val;
  logic [N_REQ-1:0]        req_sop;
  logic [N_REQ-1:0]        req_eop;
  logic [N_REQ*VBC_W-1:0]  req_vbc;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;

  logic                    u_val;
  logic                    u_sop;
  logic                    u_eop;
  logic [VBC_W-1:0]        u_vbc;
  logic [DATA_W-1:0]       u_data;
  logic                    u_ready;

  modport master (
    output req_val, req_sop, req_eop, req_vbc, req_data, u_ready,
    input  req_ready, u_val, u_sop, u_eop, u_vbc, u_data
  );

  modport slave (
    input  req_val, req_sop, req_eop, req_vbc, req_data, u_ready,
    output req_ready, u_val, u_sop, u_eop, u_vbc, u_data
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the search starts one past the previous
// winner and wraps, so the most recent owner has lowest priority.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int REQ_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [REQ_W-1:0] i_last,
  output logic [REQ_W-1:0] o_win,
  output logic             o_any
);

  // Walk the ring from last+1; the first asserted request is the winner.
  always_comb begin
    logic [REQ_W-1:0] w_idx;
    o_win = '0;
    o_any = 1'b0;
    w_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = REQ_W'((int'(i_last) + k) % N_REQ);
      if (!o_any && i_req[w_idx]) begin
        o_win = w_idx;
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/unpacker_arb.sv
// Packet-level round-robin arbiter in front of a single unpacker. A requester
// is locked in from sop to its eop transfer so packets never interleave; only
// the owner sees u_ready. A bubble cycle (GRANT) separates arbitration from
// the first forwarded beat.
module unpacker_arb
  import unpacker_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int REQ_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset_L,
  unpacker_arb_if.slave    bus,
  output logic [REQ_W-1:0] grant,
  output logic             busy,
  output logic             err
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [REQ_W-1:0]  r_grant;
  logic [REQ_W-1:0]  w_grant_nxt;
  logic [REQ_W-1:0]  r_last;
  logic [REQ_W-1:0]  w_last_nxt;
  logic              r_first;
  logic              w_first_nxt;

  logic [N_REQ-1:0]  w_cand;
  logic [REQ_W-1:0]  w_win;
  logic              w_any;

  logic              w_own_val;
  logic              w_own_sop;
  logic              w_own_eop;
  logic [VBC_W-1:0]  w_own_vbc;
  logic [DATA_W-1:0] w_own_data;
  logic              w_lock;
  logic              w_xfer;

  // Only a beat that opens a packet can win arbitration.
  assign w_cand = bus.req_val & bus.req_sop;

  rr_pick #(
    .N_REQ (N_REQ),
    .REQ_W (REQ_W)
  ) u_pick (
    .i_req  (w_cand),
    .i_last (r_last),
    .o_win  (w_win),
    .o_any  (w_any)
  );

  // Select the current owner's lane out of the packed requester buses.
  always_comb begin
    w_own_val  = bus.req_val[r_grant];
    w_own_sop  = bus.req_sop[r_grant];
    w_own_eop  = bus.req_eop[r_grant];
    w_own_vbc  = bus.req_vbc[int'(r_grant)*VBC_W +: VBC_W];
    w_own_data = bus.req_data[int'(r_grant)*DATA_W +: DATA_W];
  end

  assign w_lock = (r_state == LOCK);
  assign w_xfer = w_lock && w_own_val && bus.u_ready;

  // Next-state logic: arbitrate, take one bubble, then hold until eop moves.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_first_nxt = r_first;
    unique case (r_state)
      ARB: begin
        if (w_any) begin
          w_grant_nxt = w_win;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        w_first_nxt = 1'b1;
        w_state_nxt = LOCK;
      end
      LOCK: begin
        if (w_xfer) begin
          w_first_nxt = 1'b0;
          if (w_own_eop) begin
            w_last_nxt  = r_grant;
            w_state_nxt = ARB;
          end
        end
      end
      default: begin
        w_state_nxt = ARB;
      end
    endcase
  end

  // State and ownership registers; last starts at N_REQ-1 so requester 0 wins first.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= ARB;
      r_grant <= '0;
      r_last  <= REQ_W'(N_REQ - 1);
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_first <= w_first_nxt;
    end
  end

  // Forward the owner's beat and route u_ready back to it; idle outside LOCK.
  always_comb begin
    bus.u_val     = 1'b0;
    bus.u_sop     = 1'b0;
    bus.u_eop     = 1'b0;
    bus.u_vbc     = '0;
    bus.u_data    = '0;
    bus.req_ready = '0;
    err           = 1'b0;
    if (w_lock) begin
      bus.u_val              = w_own_val;
      bus.u_sop              = w_own_sop;
      bus.u_eop              = w_own_eop;
      bus.u_vbc              = w_own_vbc;
      bus.u_data             = w_own_data;
      bus.req_ready[r_grant] = bus.u_ready;
      // Malformed beats are still forwarded untouched; err only flags them.
      err = w_xfer && ((w_own_sop && !r_first) || vbc_over(w_own_vbc));
    end
  end

  assign grant = r_grant;
  assign busy  = (r_state != ARB);

endmodule
